// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU slice.
// Contents: opcode encodings, condition-code bit positions inside the
// {C,N,Z} flag vector, and the sequencer state encoding.
package alu_pkg;

    // Opcode encodings presented on in_op
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_NOT  = 4'd1;
    localparam logic [3:0] OP_INC  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_MOV  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SETC = 4'd11;
    localparam logic [3:0] OP_CLRC = 4'd12;
    localparam logic [3:0] OP_PASS = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_RSV  = 4'd15;

    // Bit positions inside the 3-bit condition-code vector {C,N,Z}
    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;

    // Sequencer states
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/exec_alu_seq_mul.sv
// Iterative unsigned WIDTH x WIDTH shift-add multiplier.
// Ports:
//   clk, rst_n      clock / asynchronous active-low reset
//   start           load operands and begin (ignored while abort is high)
//   abort           drop the in-flight multiply, counter cleared
//   mcand, mplier   operands, sampled on the start edge
//   done            high during the cycle whose rising edge completes the
//                   final iteration
//   product         value the accumulator takes on that edge; valid with done
// One multiplier bit is consumed per clock, so the final iteration lands
// WIDTH edges after the start edge.
module seq_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [SHW-1:0]     cnt_r;
    logic               busy_r;
    logic [2*WIDTH-1:0] sum_s;
    logic               last_s;

    // Partial product for the current multiplier bit
    assign sum_s   = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
    assign last_s  = busy_r && (cnt_r == SHW'(WIDTH - 1));
    assign done    = last_s;
    assign product = sum_s;

    // Operand load, per-cycle shift-add iteration and abort handling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {SHW{1'b0}};
            busy_r   <= 1'b0;
        end else if (abort) begin
            busy_r <= 1'b0;
            cnt_r  <= {SHW{1'b0}};
        end else if (start) begin
            acc_r    <= {(2*WIDTH){1'b0}};
            mcand_r  <= {{WIDTH{1'b0}}, mcand};
            mplier_r <= mplier;
            cnt_r    <= {SHW{1'b0}};
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= sum_s;
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            if (last_s) begin
                busy_r <= 1'b0;
                cnt_r  <= {SHW{1'b0}};
            end else begin
                cnt_r <= cnt_r + SHW'(1);
            end
        end else begin
            cnt_r <= {SHW{1'b0}};
        end
    end

endmodule

// File: rtl/exec_alu_seq.sv
// Execute-stage ALU with registered result, condition-code register and a
// multi-cycle unsigned multiplier.
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   in_valid, in_ready         issue handshake (ready only in IDLE)
//   in_op, in_src, in_dst      opcode and operands
//   in_imm                     shift amount for SHL/SHR
//   flush                      abort in-flight MUL / drop current input
//   flag_wr_en, flag_wr_data   CCR restore {C,N,Z}; wins over op updates
//   out_valid                  one-cycle pulse per completed op
//   out_result, out_hi         result (low half) and MUL high half
//   flags_q                    CCR {C,N,Z}
module exec_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_src,
    input  logic [WIDTH-1:0] in_dst,
    input  logic [SHW-1:0]   in_imm,
    input  logic             flush,
    input  logic             flag_wr_en,
    input  logic [2:0]       flag_wr_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_hi,
    output logic [2:0]       flags_q
);

    state_t             state_r;
    logic               ready_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_result_r;
    logic [WIDTH-1:0]   out_hi_r;
    logic [2:0]         flags_r;

    logic [WIDTH-1:0]   res_s;
    logic [WIDTH:0]     wide_s;
    logic               c_s;
    logic               upd_zn_s;
    logic               upd_c_s;
    logic [2:0]         single_flags_s;
    logic [2:0]         mul_flags_s;
    logic               mul_start_s;
    logic               mul_abort_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_prod_s;

    assign in_ready   = ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_hi     = out_hi_r;
    assign flags_q    = flags_r;

    assign mul_start_s = (state_r == ST_IDLE) && in_valid && !flush && (in_op == OP_MUL);
    assign mul_abort_s = flush;

    seq_multiplier #(.WIDTH(WIDTH), .SHW(SHW)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start_s),
        .abort   (mul_abort_s),
        .mcand   (in_src),
        .mplier  (in_dst),
        .done    (mul_done_s),
        .product (mul_prod_s)
    );

    // Single-cycle datapath; arithmetic and shifts run at WIDTH+1 bits so the
    // extra bit carries C (carry, borrow, or last bit shifted out)
    always_comb begin
        res_s    = {WIDTH{1'b0}};
        wide_s   = {(WIDTH+1){1'b0}};
        c_s      = flags_r[FLG_C];
        upd_zn_s = 1'b0;
        upd_c_s  = 1'b0;
        case (in_op)
            OP_NOT: begin
                res_s    = ~in_src;
                upd_zn_s = 1'b1;
            end
            OP_INC: begin
                wide_s   = {1'b0, in_src} + {{WIDTH{1'b0}}, 1'b1};
                res_s    = wide_s[WIDTH-1:0];
                c_s      = wide_s[WIDTH];
                upd_zn_s = 1'b1;
                upd_c_s  = 1'b1;
            end
            OP_DEC: begin
                wide_s   = {1'b0, in_src} - {{WIDTH{1'b0}}, 1'b1};
                res_s    = wide_s[WIDTH-1:0];
                c_s      = wide_s[WIDTH];
                upd_zn_s = 1'b1;
                upd_c_s  = 1'b1;
            end
            OP_MOV: begin
                res_s = in_dst;
            end
            OP_ADD: begin
                wide_s   = {1'b0, in_src} + {1'b0, in_dst};
                res_s    = wide_s[WIDTH-1:0];
                c_s      = wide_s[WIDTH];
                upd_zn_s = 1'b1;
                upd_c_s  = 1'b1;
            end
            OP_SUB: begin
                wide_s   = {1'b0, in_src} - {1'b0, in_dst};
                res_s    = wide_s[WIDTH-1:0];
                c_s      = wide_s[WIDTH];
                upd_zn_s = 1'b1;
                upd_c_s  = 1'b1;
            end
            OP_AND: begin
                res_s    = in_src & in_dst;
                upd_zn_s = 1'b1;
            end
            OP_OR: begin
                res_s    = in_src | in_dst;
                upd_zn_s = 1'b1;
            end
            OP_SHL: begin
                // Bit WIDTH of the widened shift is the last bit pushed out
                wide_s   = {1'b0, in_src} << in_imm;
                res_s    = wide_s[WIDTH-1:0];
                c_s      = wide_s[WIDTH];
                upd_zn_s = 1'b1;
                upd_c_s  = (in_imm != {SHW{1'b0}});
            end
            OP_SHR: begin
                // Guard bit below the LSB catches the last bit shifted out
                wide_s   = {in_src, 1'b0} >> in_imm;
                res_s    = wide_s[WIDTH:1];
                c_s      = wide_s[0];
                upd_zn_s = 1'b1;
                upd_c_s  = (in_imm != {SHW{1'b0}});
            end
            OP_SETC: begin
                c_s     = 1'b1;
                upd_c_s = 1'b1;
            end
            OP_CLRC: begin
                c_s     = 1'b0;
                upd_c_s = 1'b1;
            end
            OP_PASS: begin
                res_s = in_src;
            end
            default: begin
                res_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Next CCR values for a completing single-cycle op and for MUL
    always_comb begin
        single_flags_s        = flags_r;
        single_flags_s[FLG_C] = upd_c_s ? c_s : flags_r[FLG_C];
        if (upd_zn_s) begin
            single_flags_s[FLG_N] = res_s[WIDTH-1];
            single_flags_s[FLG_Z] = (res_s == {WIDTH{1'b0}});
        end else begin
            single_flags_s[FLG_N] = flags_r[FLG_N];
            single_flags_s[FLG_Z] = flags_r[FLG_Z];
        end
        mul_flags_s        = 3'b000;
        mul_flags_s[FLG_N] = mul_prod_s[2*WIDTH-1];
        mul_flags_s[FLG_Z] = (mul_prod_s == {(2*WIDTH){1'b0}});
    end

    // Sequencer, registered outputs and CCR; a restore write lands last so it
    // overrides any flag update from an op completing on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ready_r      <= 1'b1;
            out_valid_r  <= 1'b0;
            out_result_r <= {WIDTH{1'b0}};
            out_hi_r     <= {WIDTH{1'b0}};
            flags_r      <= 3'b000;
        end else begin
            if (flush) begin
                state_r     <= ST_IDLE;
                ready_r     <= 1'b1;
                out_valid_r <= 1'b0;
            end else if ((state_r == ST_IDLE) && in_valid) begin
                if (in_op == OP_MUL) begin
                    state_r     <= ST_MUL_RUN;
                    ready_r     <= 1'b0;
                    out_valid_r <= 1'b0;
                end else begin
                    out_valid_r  <= 1'b1;
                    out_result_r <= res_s;
                    out_hi_r     <= {WIDTH{1'b0}};
                    flags_r      <= single_flags_s;
                end
            end else if ((state_r == ST_MUL_RUN) && mul_done_s) begin
                state_r      <= ST_IDLE;
                ready_r      <= 1'b1;
                out_valid_r  <= 1'b1;
                out_result_r <= mul_prod_s[WIDTH-1:0];
                out_hi_r     <= mul_prod_s[2*WIDTH-1:WIDTH];
                flags_r      <= mul_flags_s;
            end else begin
                out_valid_r <= 1'b0;
            end
            if (flag_wr_en) begin
                flags_r <= flag_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_exec_alu_seq.sv
// Self-checking bench for exec_alu_seq (WIDTH=16): directed vector table,
// hand-written multi-cycle sequences, and randomized ops against a model.
module tb_exec_alu_seq;
    import alu_pkg::*;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [W-1:0]  in_src;
    logic [W-1:0]  in_dst;
    logic [3:0]    in_imm;
    logic          flush;
    logic          flag_wr_en;
    logic [2:0]    flag_wr_data;
    logic          out_valid;
    logic [W-1:0]  out_result;
    logic [W-1:0]  out_hi;
    logic [2:0]    flags_q;

    int checks = 0;
    int errors = 0;

    exec_alu_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_src       (in_src),
        .in_dst       (in_dst),
        .in_imm       (in_imm),
        .flush        (flush),
        .flag_wr_en   (flag_wr_en),
        .flag_wr_data (flag_wr_data),
        .out_valid    (out_valid),
        .out_result   (out_result),
        .out_hi       (out_hi),
        .flags_q      (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] s;
        logic [W-1:0] d;
        logic [3:0]   imm;
        logic [W-1:0] er;
        logic [2:0]   ef;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour of single-cycle ops, flags as {C,N,Z}
    function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] s, input logic [W-1:0] d,
                                   input logic [3:0] imm, input logic [2:0] fi,
                                   output logic [W-1:0] r, output logic [2:0] fo);
        int unsigned a, b, t, sh;
        logic c, n, z;
        bit zn;
        a = s; b = d; sh = imm;
        c = fi[2]; n = fi[1]; z = fi[0];
        r = '0; zn = 0;
        case (op)
            4'd1: begin r = ~s; zn = 1; end
            4'd2: begin t = a + 1; r = t[15:0]; c = (t > 65535); zn = 1; end
            4'd3: begin r = s - 16'd1; c = (a == 0); zn = 1; end
            4'd4: r = d;
            4'd5: begin t = a + b; r = t[15:0]; c = (t > 65535); zn = 1; end
            4'd6: begin r = s - d; c = (a < b); zn = 1; end
            4'd7: begin r = s & d; zn = 1; end
            4'd8: begin r = s | d; zn = 1; end
            4'd9: begin
                t = (a << sh) & 32'hFFFF; r = t[15:0]; zn = 1;
                if (sh != 0) c = ((a >> (16 - sh)) & 32'd1) != 0;
            end
            4'd10: begin
                r = s >> imm; zn = 1;
                if (sh != 0) c = ((a >> (sh - 1)) & 32'd1) != 0;
            end
            4'd11: c = 1'b1;
            4'd12: c = 1'b0;
            4'd13: r = s;
            default: r = '0;
        endcase
        if (zn) begin
            z = (r == 16'd0);
            n = r[15];
        end
        fo = {c, n, z};
    endfunction

    task automatic send(input logic [3:0] op, input logic [W-1:0] s, input logic [W-1:0] d,
                        input logic [3:0] imm, input logic fwe, input logic [2:0] fwd);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_src = s; in_dst = d; in_imm = imm;
        flag_wr_en = fwe; flag_wr_data = fwd;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flag_wr_en = 1'b0;
    endtask

    // Counts edges after the accept until out_valid, bounded at 40
    task automatic wait_mul(output int cyc, output bit rdy_low);
        cyc = 0; rdy_low = 1;
        while (!out_valid && cyc < 40) begin
            if (in_ready !== 1'b0) rdy_low = 0;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        logic [2:0]   mflags;
        logic [W-1:0] er;
        logic [W-1:0] eh;
        logic [2:0]   ef;
        logic [31:0]  p;
        int           cyc;
        bit           rl;
        bit           saw;

        rst_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_src = '0; in_dst = '0;
        in_imm = 4'd0; flush = 1'b0; flag_wr_en = 1'b0; flag_wr_data = 3'b000;
        #12;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_result", out_result, 0);
        chk("reset out_hi", out_hi, 0);
        chk("reset flags", flags_q, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // op, src, dst, imm, expected result, expected {C,N,Z}
        tbl.push_back('{4'd5,  16'hFFFF, 16'h0001, 4'd0,  16'h0000, 3'b101});
        tbl.push_back('{4'd6,  16'h0003, 16'h0005, 4'd0,  16'hFFFE, 3'b110});
        tbl.push_back('{4'd4,  16'h0000, 16'h1234, 4'd0,  16'h1234, 3'b110});
        tbl.push_back('{4'd9,  16'h8001, 16'h0000, 4'd1,  16'h0002, 3'b100});
        tbl.push_back('{4'd10, 16'hABCD, 16'h0000, 4'd0,  16'hABCD, 3'b110});
        tbl.push_back('{4'd11, 16'h5555, 16'h0000, 4'd0,  16'h0000, 3'b110});
        tbl.push_back('{4'd12, 16'h5555, 16'h0000, 4'd0,  16'h0000, 3'b010});
        tbl.push_back('{4'd13, 16'h4321, 16'h0000, 4'd0,  16'h4321, 3'b010});
        tbl.push_back('{4'd0,  16'h1111, 16'h2222, 4'd0,  16'h0000, 3'b010});
        tbl.push_back('{4'd1,  16'h0000, 16'h0000, 4'd0,  16'hFFFF, 3'b010});
        tbl.push_back('{4'd3,  16'h0000, 16'h0000, 4'd0,  16'hFFFF, 3'b110});
        tbl.push_back('{4'd2,  16'hFFFF, 16'h0000, 4'd0,  16'h0000, 3'b101});
        tbl.push_back('{4'd7,  16'hF0F0, 16'h0FF0, 4'd0,  16'h00F0, 3'b100});
        tbl.push_back('{4'd8,  16'h0000, 16'h0000, 4'd0,  16'h0000, 3'b101});
        tbl.push_back('{4'd15, 16'h7777, 16'h8888, 4'd0,  16'h0000, 3'b101});
        tbl.push_back('{4'd10, 16'h0003, 16'h0000, 4'd2,  16'h0000, 3'b101});
        tbl.push_back('{4'd9,  16'h0001, 16'h0000, 4'd15, 16'h8000, 3'b010});

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].op, tbl[i].s, tbl[i].d, tbl[i].imm, 1'b0, 3'b000);
            chk($sformatf("vec%0d valid", i), out_valid, 1);
            chk($sformatf("vec%0d result", i), out_result, tbl[i].er);
            chk($sformatf("vec%0d flags", i), flags_q, tbl[i].ef);
            chk($sformatf("vec%0d hi", i), out_hi, 0);
        end
        mflags = tbl[tbl.size()-1].ef;
        @(posedge clk); #1;
        chk("valid clears when idle", out_valid, 0);

        // MUL latency, ready low throughout, back-to-back issue in done cycle
        send(4'd14, 16'h00FF, 16'h0101, 4'd0, 1'b0, 3'b000);
        wait_mul(cyc, rl);
        chk("mul latency", cyc, 16);
        chk("mul ready low", rl, 1);
        chk("mul result", out_result, 16'hFFFF);
        chk("mul hi", out_hi, 16'h0000);
        chk("mul flags", flags_q, 3'b000);
        chk("mul ready back", in_ready, 1);
        send(4'd5, 16'h0001, 16'h0001, 4'd0, 1'b0, 3'b000);
        chk("b2b valid", out_valid, 1);
        chk("b2b result", out_result, 16'h0002);
        chk("b2b hi", out_hi, 16'h0000);

        // Flush at cycle 5 of a MUL
        send(4'd11, 16'h0000, 16'h0000, 4'd0, 1'b0, 3'b000);
        chk("setc flags", flags_q, 3'b100);
        send(4'd14, 16'h0003, 16'h0005, 4'd0, 1'b0, 3'b000);
        repeat (4) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush valid", out_valid, 0);
        chk("flush ready", in_ready, 1);
        chk("flush flags", flags_q, 3'b100);
        saw = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1;
        end
        chk("flush no late result", saw, 0);
        // Flush in IDLE drops the presented op
        @(negedge clk); flush = 1'b1; in_valid = 1'b1; in_op = 4'd12;
        @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0;
        chk("idle flush drop valid", out_valid, 0);
        chk("idle flush drop flags", flags_q, 3'b100);

        // CCR restore wins over a completing ADD
        send(4'd5, 16'h0010, 16'h0020, 4'd0, 1'b1, 3'b010);
        chk("fwr result", out_result, 16'h0030);
        chk("fwr flags", flags_q, 3'b010);

        // Asynchronous reset mid-MUL
        send(4'd14, 16'hFFFF, 16'hFFFF, 4'd0, 1'b0, 3'b000);
        repeat (7) @(posedge clk);
        @(negedge clk); #2; rst_n = 1'b0; #1;
        chk("rst mid valid", out_valid, 0);
        chk("rst mid result", out_result, 0);
        chk("rst mid hi", out_hi, 0);
        chk("rst mid flags", flags_q, 0);
        chk("rst mid ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        saw = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1;
        end
        chk("rst no late result", saw, 0);
        mflags = 3'b000;

        // Randomized ops against the reference model
        repeat (150) begin
            logic [3:0]   op;
            logic [W-1:0] s, d;
            logic [3:0]   imm;
            logic         fwe;
            logic [2:0]   fwd;
            op  = 4'($urandom_range(0, 15));
            s   = 16'($urandom);
            d   = 16'($urandom);
            imm = 4'($urandom_range(0, 15));
            fwe = ($urandom_range(0, 9) == 0);
            fwd = 3'($urandom);
            if (op == 4'd14) begin
                p  = s * d;
                er = p[15:0];
                eh = p[31:16];
                ef = {1'b0, p[31], p == 32'd0};
            end else begin
                ref_op(op, s, d, imm, mflags, er, ef);
                eh = '0;
            end
            if (fwe) ef = fwd;
            send(op, s, d, imm, fwe, fwd);
            if (op == 4'd14) begin
                wait_mul(cyc, rl);
                chk("rand mul latency", cyc, 16);
                // restore write was on the accept edge; MUL overwrites later
                if (fwe) ef = {1'b0, p[31], p == 32'd0};
            end
            chk($sformatf("rand op%0d valid", op), out_valid, 1);
            chk($sformatf("rand op%0d result", op), out_result, er);
            chk($sformatf("rand op%0d hi", op), out_hi, eh);
            chk($sformatf("rand op%0d flags", op), flags_q, ef);
            mflags = ef;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
